// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM states and
// the legal-opcode decode used by both the design and its bench.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_EQ  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_EQ: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Request/response front end for the combinational ALU: IDLE -> EXEC -> RESP.
// Define ALU_SEQ_FWD_EN to add the result accumulator and the Req_UseAcc input.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Req_Valid,
  output logic             Req_Ready,
  input  logic [3:0]       Req_Op,
  input  logic [WIDTH-1:0] Req_A,
  input  logic [WIDTH-1:0] Req_B,
`ifdef ALU_SEQ_FWD_EN
  input  logic             Req_UseAcc,
`endif
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [3:0]       ALU_Sel,
  input  logic [WIDTH-1:0] ALU_Res,
  input  logic             ALU_Carry,
  input  logic             ALU_Zero,
  input  logic             ALU_Ovf,
  output logic             Resp_Valid,
  input  logic             Resp_Ready,
  output logic [WIDTH-1:0] Resp_Data,
  output logic             Resp_Carry,
  output logic             Resp_Zero,
  output logic             Resp_Ovf,
  output logic             Resp_Err,
  output logic             Sticky_Ovf,
  input  logic             Sticky_Clr,
  output logic [CNT_W-1:0] Op_Count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_next;
  logic   err_q;
  logic   accept;
  logic   capture;
  logic   legal_done;

`ifdef ALU_SEQ_FWD_EN
  logic [WIDTH-1:0] acc;
`endif

  assign accept     = Req_Valid && Req_Ready;
  assign capture    = (state == EXEC);
  assign legal_done = capture && !err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    Req_Ready  = 1'b0;
    Resp_Valid = 1'b0;
    case (state)
      IDLE: begin
        Req_Ready = 1'b1;
        if (Req_Valid) state_next = EXEC;
      end
      EXEC: state_next = RESP;
      RESP: begin
        Resp_Valid = 1'b1;
        if (Resp_Ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Illegal opcodes still run the ALU, but as a harmless AND whose result is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_A   <= '0;
      ALU_B   <= '0;
      ALU_Sel <= OP_AND;
      err_q   <= 1'b0;
    end else if (accept) begin
`ifdef ALU_SEQ_FWD_EN
      ALU_A <= Req_UseAcc ? acc : Req_A;
`else
      ALU_A <= Req_A;
`endif
      ALU_B   <= Req_B;
      ALU_Sel <= is_legal_op(Req_Op) ? Req_Op : OP_AND;
      err_q   <= !is_legal_op(Req_Op);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Resp_Data  <= '0;
      Resp_Carry <= 1'b0;
      Resp_Zero  <= 1'b0;
      Resp_Ovf   <= 1'b0;
      Resp_Err   <= 1'b0;
    end else if (capture) begin
      Resp_Data  <= err_q ? '0 : ALU_Res;
      Resp_Carry <= !err_q && ALU_Carry;
      Resp_Zero  <= !err_q && ALU_Zero;
      Resp_Ovf   <= !err_q && ALU_Ovf;
      Resp_Err   <= err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          Op_Count <= '0;
    else if (legal_done) Op_Count <= Op_Count + CNT_ONE;
  end

  // A new overflow takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     Sticky_Ovf <= 1'b0;
    else if (legal_done && ALU_Ovf) Sticky_Ovf <= 1'b1;
    else if (Sticky_Clr)            Sticky_Ovf <= 1'b0;
  end

`ifdef ALU_SEQ_FWD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          acc <= '0;
    else if (legal_done) acc <= ALU_Res;
  end
`endif

endmodule
